// File: rtl/reg_file_rename_if.sv
// reg_file_rename_if: decoder/ROB/RS-facing bundle of the renaming register file.
//   master: issue/commit/flush/read-index driver (decoder + ROB side)
//   slave : the register file, returning source values, busy bits, tags, busy count
interface reg_file_rename_if #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int ROB_BIT = 4,
    parameter int NRD     = 2
) ();
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);
    logic                   rdy_in;
    logic                   clear_in;
    logic                   commit_valid;
    logic [RW-1:0]          commit_rd;
    logic [XLEN-1:0]        commit_data;
    logic [ROB_BIT-1:0]     commit_tag;
    logic                   issue_valid;
    logic [RW-1:0]          issue_rd;
    logic [ROB_BIT-1:0]     issue_tag;
    logic [NRD*RW-1:0]      rd_id;
    logic [NRD*XLEN-1:0]    rd_val;
    logic [NRD-1:0]         rd_busy;
    logic [NRD*ROB_BIT-1:0] rd_tag;
    logic [CW-1:0]          busy_cnt;
    modport master (
        output rdy_in, clear_in, commit_valid, commit_rd, commit_data, commit_tag,
               issue_valid, issue_rd, issue_tag, rd_id,
        input  rd_val, rd_busy, rd_tag, busy_cnt
    );
    modport slave (
        input  rdy_in, clear_in, commit_valid, commit_rd, commit_data, commit_tag,
               issue_valid, issue_rd, issue_tag, rd_id,
        output rd_val, rd_busy, rd_tag, busy_cnt
    );
endinterface

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with busy bits and ROB rename tags.
//   clk_in/rst_in : clock, synchronous active-high reset
//   bus (slave)   : issue marks rd busy, commit writes data and frees rd on tag match,
//                   clear_in drops all busy bits, NRD combinational read ports with
//                   same-cycle commit bypass, registered busy_cnt
module reg_file_rename #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int ROB_BIT = 4,
    parameter int NRD     = 2
) (
    input logic          clk_in,
    input logic          rst_in,
    reg_file_rename_if.slave bus
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);
    logic [XLEN-1:0]    val_q [NREG];
    logic [XLEN-1:0]    val_d [NREG];
    logic [ROB_BIT-1:0] tag_q [NREG];
    logic [ROB_BIT-1:0] tag_d [NREG];
    logic [NREG-1:0]    busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NRD*XLEN-1:0]    rd_val;
    logic [NRD-1:0]         rd_busy;
    logic [NRD*ROB_BIT-1:0] rd_tag;
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        cnt_d  = '0;
        if (bus.commit_valid && bus.commit_rd != '0) begin
            val_d[bus.commit_rd] = bus.commit_data;
            // only the producer that still owns the register may free it
            if (busy_q[bus.commit_rd] && tag_q[bus.commit_rd] == bus.commit_tag)
                busy_d[bus.commit_rd] = 1'b0;
        end
        // issue is applied after commit so it wins on the same rd
        if (bus.clear_in)
            busy_d = '0;
        else if (bus.issue_valid && bus.issue_rd != '0) begin
            busy_d[bus.issue_rd] = 1'b1;
            tag_d[bus.issue_rd]  = bus.issue_tag;
        end
        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + CW'(busy_d[i]);
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            val_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else if (bus.rdy_in) begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RW-1:0] id;
        logic          byp;
        assign id  = bus.rd_id[k*RW +: RW];
        // the retiring producer's value is forwarded in the same cycle
        assign byp = busy_q[id] && bus.commit_valid && bus.commit_rd == id &&
                     id != '0 && tag_q[id] == bus.commit_tag;
        assign rd_val[k*XLEN +: XLEN]       = byp ? bus.commit_data : val_q[id];
        assign rd_busy[k]                   = busy_q[id] && !byp;
        assign rd_tag[k*ROB_BIT +: ROB_BIT] = tag_q[id];
    end
    assign bus.rd_val   = rd_val;
    assign bus.rd_busy  = rd_busy;
    assign bus.rd_tag   = rd_tag;
    assign bus.busy_cnt = cnt_q;
endmodule
